// File: rtl/csr_bus_arbiter_pkg.sv
// Shared definitions for the two-port CSR bus arbiter: FSM state encodings and port ids.
package csr_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/csr_bus_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; the last_grant register lives in the caller.
module csr_bus_arbiter_rr_arb2
    import csr_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = PORT_M0;
        if (req == 2'b11) begin
            // On a tie the port that did not win last time goes first.
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = PORT_M1;
        end
    end

endmodule

// File: rtl/csr_bus_arbiter.sv
// Round-robin arbiter sharing one bram-style CSR port between two requesters.
// One transaction in flight; valid/ready: req is held until its one-cycle ack, and must be low the cycle after.
module csr_bus_arbiter
    import csr_bus_arbiter_pkg::*;
#(
    parameter int ADD_WIDTH = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 m0_req,
    input  logic                 m0_wr,
    input  logic [ADD_WIDTH-1:0] m0_addr,
    input  logic [31:0]          m0_wdata,
    output logic                 m0_ack,
    output logic [31:0]          m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_wr,
    input  logic [ADD_WIDTH-1:0] m1_addr,
    input  logic [31:0]          m1_wdata,
    output logic                 m1_ack,
    output logic [31:0]          m1_rdata,
    output logic [ADD_WIDTH-1:0] bram_addr,
    output logic                 bram_wr,
    output logic [31:0]          bram_wr_data,
    output logic                 bram_rd,
    input  logic [31:0]          bram_rd_data,
    output logic [1:0]           dbg_state
);

    arb_state_t state_q, state_d;

    logic                 last_grant;
    logic                 grant_valid;
    logic                 grant_id;
    logic                 id_q;
    logic                 wr_q;
    logic                 sel_wr;
    logic [ADD_WIDTH-1:0] sel_addr;
    logic [31:0]          sel_wdata;
    logic                 take;

    csr_bus_arbiter_rr_arb2 u_rr_arb2 (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_wr    = grant_id ? m1_wr    : m0_wr;
    assign sel_addr  = grant_id ? m1_addr  : m0_addr;
    assign sel_wdata = grant_id ? m1_wdata : m0_wdata;
    assign take      = (state_q == ST_IDLE) && grant_valid;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = wr_q ? ST_ACK : ST_WAIT;
            ST_WAIT:  state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes and acks are flops set on entry to their state, so no input reaches an output combinationally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            last_grant   <= PORT_M1;
            id_q         <= PORT_M0;
            wr_q         <= 1'b0;
            bram_addr    <= '0;
            bram_wr_data <= '0;
            bram_wr      <= 1'b0;
            bram_rd      <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
        end else begin
            state_q <= state_d;
            bram_wr <= take && sel_wr;
            bram_rd <= take && !sel_wr;
            m0_ack  <= (state_d == ST_ACK) && (id_q == PORT_M0);
            m1_ack  <= (state_d == ST_ACK) && (id_q == PORT_M1);
            if (take) begin
                id_q         <= grant_id;
                wr_q         <= sel_wr;
                bram_addr    <= sel_addr;
                bram_wr_data <= sel_wdata;
                last_grant   <= grant_id;
            end
            if (state_q == ST_WAIT) begin
                if (id_q == PORT_M1) m1_rdata <= bram_rd_data;
                else                 m0_rdata <= bram_rd_data;
            end
        end
    end

`ifndef SYNTHESIS
    a_strobe_onehot: assert property (@(posedge aclk) disable iff (!aresetn) !(bram_wr && bram_rd));
    a_ack_onehot:    assert property (@(posedge aclk) disable iff (!aresetn) !(m0_ack && m1_ack));
`endif

endmodule
